// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl
// Sequencer between a PS/2 byte receiver/transmitter pair and the rest of
// the system. After reset it sends the enable-data-reporting command (0xF4),
// waits for the 0xFA acknowledge (retrying forever on any other byte or on
// timeout), then assembles 3-byte mouse stream packets into registered
// movement and button values.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high
//   rx_done_tick  in  : one-cycle pulse, rx_data valid in that cycle
//   rx_data       in  : received byte
//   rx_en         out : receiver enable, low while we are transmitting
//   tx_start      out : one-cycle request to the transmitter
//   tx_data       out : byte to send (always 0xF4)
//   tx_done_tick  in  : one-cycle pulse when the transmitter has finished
//   init_done     out : sticky, high once 0xFA has been accepted
//   xm, ym        out : signed 9-bit movement {sign, magnitude byte}
//   btnm          out : buttons {middle, right, left}
//   m_done_tick   out : one-cycle pulse when xm/ym/btnm carry a new packet
//   state_dbg     out : current FSM state encoding
//
// Handshake: all *_tick / tx_start signals are single-cycle strobes with no
// back-pressure; a strobe is consumed in the cycle it is high, and data
// qualified by a strobe is valid only in that same cycle.
module ps2_mouse_ctrl #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done_tick,
  output logic       init_done,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic       m_done_tick,
  output logic [2:0] state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    SEND     = 3'd0,
    WAIT_TX  = 3'd1,
    WAIT_ACK = 3'd2,
    PKT1     = 3'd3,
    PKT2     = 3'd4,
    PKT3     = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo;

  // Only the fields of byte0 that reach the outputs are kept.
  logic       x_sign;
  logic       y_sign;
  logic [2:0] btn_lat;
  logic [7:0] byte1;
  logic [7:0] byte2;

  assign tmo       = (tmo_cnt == TMO_LAST);
  assign tx_data   = 8'hF4;
  assign state_dbg = state;

  // rx_en is registered alongside the state transition so that it always
  // matches the state the FSM is in (low only in SEND and WAIT_TX).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEND;
      tmo_cnt     <= '0;
      rx_en       <= 1'b0;
      tx_start    <= 1'b0;
      init_done   <= 1'b0;
      xm          <= '0;
      ym          <= '0;
      btnm        <= '0;
      m_done_tick <= 1'b0;
      x_sign      <= 1'b0;
      y_sign      <= 1'b0;
      btn_lat     <= '0;
      byte1       <= '0;
      byte2       <= '0;
    end else begin
      tx_start    <= 1'b0;
      m_done_tick <= 1'b0;
      // Free-running count; any byte or state change restarts it. The
      // transition branches below also clear it.
      tmo_cnt     <= tmo_cnt + 1'b1;
      if (rx_done_tick) tmo_cnt <= '0;

      case (state)
        SEND: begin
          tx_start <= 1'b1;
          rx_en    <= 1'b0;
          tmo_cnt  <= '0;
          state    <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_done_tick) begin
            rx_en   <= 1'b1;
            tmo_cnt <= '0;
            state   <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (rx_done_tick) begin
            tmo_cnt <= '0;
            if (rx_data == 8'hFA) begin
              init_done <= 1'b1;
              state     <= PKT1;
            end else begin
              rx_en <= 1'b0;
              state <= SEND;
            end
          end else if (tmo) begin
            rx_en   <= 1'b0;
            tmo_cnt <= '0;
            state   <= SEND;
          end
        end

        PKT1: begin
          // Bit 3 is always set in a genuine first byte; anything else is
          // dropped so the stream can realign on the next candidate.
          if (rx_done_tick && rx_data[3]) begin
            x_sign  <= rx_data[4];
            y_sign  <= rx_data[5];
            btn_lat <= rx_data[2:0];
            tmo_cnt <= '0;
            state   <= PKT2;
          end
        end

        PKT2: begin
          if (rx_done_tick) begin
            byte1   <= rx_data;
            tmo_cnt <= '0;
            state   <= PKT3;
          end else if (tmo) begin
            tmo_cnt <= '0;
            state   <= PKT1;
          end
        end

        PKT3: begin
          if (rx_done_tick) begin
            byte2   <= rx_data;
            tmo_cnt <= '0;
            state   <= DONE;
          end else if (tmo) begin
            tmo_cnt <= '0;
            state   <= PKT1;
          end
        end

        DONE: begin
          xm          <= {x_sign, byte1};
          ym          <= {y_sign, byte2};
          btnm        <= btn_lat;
          m_done_tick <= 1'b1;
          tmo_cnt     <= '0;
          state       <= PKT1;
        end

        default: begin
          rx_en   <= 1'b0;
          tmo_cnt <= '0;
          state   <= SEND;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
module tb_ps2_mouse_ctrl;

  localparam int TMO = 20;

  localparam logic [31:0] S_SEND     = 32'd0;
  localparam logic [31:0] S_WAIT_TX  = 32'd1;
  localparam logic [31:0] S_WAIT_ACK = 32'd2;
  localparam logic [31:0] S_PKT1     = 32'd3;
  localparam logic [31:0] S_PKT2     = 32'd4;
  localparam logic [31:0] S_PKT3     = 32'd5;
  localparam logic [31:0] S_DONE     = 32'd6;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic       rx_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       init_done;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  ps2_mouse_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .init_done    (init_done),
    .xm           (xm),
    .ym           (ym),
    .btnm         (btnm),
    .m_done_tick  (m_done_tick),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int mdone_cnt = 0;
  int mdone_base;

  always @(posedge clk) begin
    if (m_done_tick) mdone_cnt <= mdone_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    cyc();
    rx_done_tick = 1'b0;
  endtask

  task automatic tx_done();
    tx_done_tick = 1'b1;
    cyc();
    tx_done_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_en"},     32'(rx_en),       32'd0);
    chk({tag, "_tx_start"},  32'(tx_start),    32'd0);
    chk({tag, "_init_done"}, 32'(init_done),   32'd0);
    chk({tag, "_xm"},        32'(xm),          32'd0);
    chk({tag, "_ym"},        32'(ym),          32'd0);
    chk({tag, "_btnm"},      32'(btnm),        32'd0);
    chk({tag, "_mdone"},     32'(m_done_tick), 32'd0);
    chk({tag, "_state"},     32'(state_dbg),   S_SEND);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    repeat (3) cyc();
    chk_all_zero("reset");

    // Init: command pulse, then silence in WAIT_TX
    reset = 1'b0;
    cyc();
    chk("init_tx_start_hi", 32'(tx_start), 32'd1);
    chk("init_tx_data",     32'(tx_data),  32'hF4);
    chk("init_rx_en_lo",    32'(rx_en),    32'd0);
    cyc();
    chk("init_tx_start_1cyc", 32'(tx_start), 32'd0);
    repeat (30) cyc();
    chk("wait_tx_no_tmo", 32'(state_dbg), S_WAIT_TX);
    chk("wait_tx_rx_en",  32'(rx_en),     32'd0);
    tx_done();
    chk("ack_rx_en_hi", 32'(rx_en), 32'd1);

    // NAK retry
    send_byte(8'hFE);
    chk("nak_state_send", 32'(state_dbg), S_SEND);
    chk("nak_rx_en_lo",   32'(rx_en),     32'd0);
    cyc();
    chk("nak_retry_tx_start", 32'(tx_start),  32'd1);
    chk("nak_no_init",        32'(init_done), 32'd0);
    tx_done();

    // Acknowledge timeout: WAIT_ACK for TMO cycles goes back to SEND
    repeat (TMO - 1) cyc();
    chk("ack_pre_tmo", 32'(state_dbg), S_WAIT_ACK);
    cyc();
    chk("ack_tmo_send", 32'(state_dbg), S_SEND);
    cyc();
    chk("ack_tmo_tx_start", 32'(tx_start), 32'd1);
    tx_done();
    send_byte(8'hFA);
    chk("init_done_hi", 32'(init_done), 32'd1);
    chk("init_pkt1",    32'(state_dbg), S_PKT1);

    // Packet 0x39 0x05 0xF0
    mdone_base = mdone_cnt;
    send_byte(8'h39);
    send_byte(8'h05);
    send_byte(8'hF0);
    chk("pkt_latency_mdone_lo", 32'(m_done_tick), 32'd0);
    cyc();
    chk("pkt_mdone_hi", 32'(m_done_tick), 32'd1);
    chk("pkt_xm",       32'(xm),          32'h105);
    chk("pkt_ym",       32'(ym),          32'h1F0);
    chk("pkt_btnm",     32'(btnm),        32'h1);
    cyc();
    chk("pkt_mdone_1cyc", 32'(m_done_tick), 32'd0);
    chk("pkt_xm_hold",    32'(xm),          32'h105);
    repeat (2) cyc();
    chk("pkt_mdone_count", 32'(mdone_cnt - mdone_base), 32'd1);

    // PKT1 has no timeout; then resync on a byte without bit 3
    repeat (100) cyc();
    chk("pkt1_no_tmo", 32'(state_dbg), S_PKT1);
    mdone_base = mdone_cnt;
    send_byte(8'h00);
    chk("resync_discard", 32'(state_dbg), S_PKT1);
    send_byte(8'h08);
    send_byte(8'h7F);
    send_byte(8'h01);
    cyc();
    chk("resync_mdone", 32'(m_done_tick), 32'd1);
    chk("resync_xm",    32'(xm),          32'h07F);
    chk("resync_ym",    32'(ym),          32'h001);
    chk("resync_btnm",  32'(btnm),        32'h0);
    repeat (2) cyc();
    chk("resync_mdone_count", 32'(mdone_cnt - mdone_base), 32'd1);

    // Timeout in PKT3 drops the partial packet
    send_byte(8'h08);
    send_byte(8'h10);
    repeat (TMO - 1) cyc();
    chk("pkt3_pre_tmo", 32'(state_dbg), S_PKT3);
    cyc();
    chk("pkt3_tmo_pkt1", 32'(state_dbg), S_PKT1);
    send_byte(8'h08);
    send_byte(8'h02);
    send_byte(8'h03);
    cyc();
    chk("tmo_mdone", 32'(m_done_tick), 32'd1);
    chk("tmo_xm",    32'(xm),          32'h002);
    chk("tmo_ym",    32'(ym),          32'h003);

    // Byte arriving in the same cycle the PKT2 timeout would fire
    send_byte(8'h18);
    repeat (TMO - 1) cyc();
    chk("pkt2_pre_tmo", 32'(state_dbg), S_PKT2);
    send_byte(8'h44);
    chk("simul_byte_wins", 32'(state_dbg), S_PKT3);
    send_byte(8'h55);
    chk("simul_done_state", 32'(state_dbg), S_DONE);
    cyc();
    chk("simul_xm",   32'(xm),   32'h144);
    chk("simul_ym",   32'(ym),   32'h055);
    chk("simul_btnm", 32'(btnm), 32'h0);

    // Reset in the middle of a packet
    send_byte(8'h0F);
    send_byte(8'h01);
    chk("midpkt_pkt3", 32'(state_dbg), S_PKT3);
    reset = 1'b1;
    cyc();
    chk_all_zero("midpkt_reset");
    reset = 1'b0;
    cyc();
    chk("midpkt_fresh_tx_start", 32'(tx_start), 32'd1);
    chk("midpkt_rx_en_lo",       32'(rx_en),    32'd0);
    cyc();
    chk("midpkt_tx_start_1cyc", 32'(tx_start), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
